// File: rtl/leaf_rx_tx_interface.sv
// Leaf-side BFT interface: RX packets unpack into a FWFT FIFO, TX stream is packetized to the BFT.
// Optional statistics counters (rx_cnt, bounce_cnt) are enabled with `define LEAF_IF_STATS_EN.
module leaf_rx_tx_interface #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [48:0] din_leaf_bft2interface,
    output logic [48:0] dout_leaf_interface2bft,
    output logic        resend,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready
`ifdef LEAF_IF_STATS_EN
    ,
    output logic [15:0] rx_cnt,
    output logic [15:0] bounce_cnt
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             cfg_valid;
    logic [4:0]       dest_leaf;
    logic [3:0]       dest_port;

    logic             rx_vld;
    logic             rx_cfg;
    logic             rx_data;
    logic             full;
    logic             bounce_now;
    logic             push;
    logic             pop;
    logic             tx_fire;
    logic [48:0]      dout_nxt;

    assign rx_vld     = din_leaf_bft2interface[48];
    assign rx_cfg     = rx_vld && (din_leaf_bft2interface[42:39] == 4'd0);
    assign rx_data    = rx_vld && (din_leaf_bft2interface[42:39] != 4'd0);
    // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a push.
    assign full       = (count == FULL_CNT);
    assign bounce_now = rx_data && full;
    assign push       = rx_data && !full;
    assign m_valid    = (count != '0);
    assign m_data     = mem[rd_ptr];
    assign pop        = m_valid && m_ready;
    assign s_ready    = cfg_valid && !bounce_now;
    assign tx_fire    = s_valid && s_ready;

    always_comb begin
        dout_nxt = '0;
        if (bounce_now) begin
            dout_nxt     = din_leaf_bft2interface;
            dout_nxt[38] = 1'b1;
        end else if (tx_fire) begin
            dout_nxt = {1'b1, dest_leaf, dest_port, 1'b0, 6'b0, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din_leaf_bft2interface[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            count                   <= '0;
            cfg_valid               <= 1'b0;
            dest_leaf               <= '0;
            dest_port               <= '0;
            dout_leaf_interface2bft <= '0;
            resend                  <= 1'b0;
        end else begin
            dout_leaf_interface2bft <= dout_nxt;
            resend                  <= bounce_now;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (rx_cfg) begin
                cfg_valid <= 1'b1;
                dest_leaf <= din_leaf_bft2interface[8:4];
                dest_port <= din_leaf_bft2interface[3:0];
            end
        end
    end

`ifdef LEAF_IF_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt     <= '0;
            bounce_cnt <= '0;
        end else begin
            if (push && (rx_cnt != 16'hFFFF)) begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (bounce_now && (bounce_cnt != 16'hFFFF)) begin
                bounce_cnt <= bounce_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_leaf_rx_tx_interface.sv
// Self-checking bench for leaf_rx_tx_interface: queue-based reference model plus directed and random stimulus.
module tb_leaf_rx_tx_interface;

    logic        clk;
    logic        reset_n;
    logic [48:0] din;
    logic [48:0] dout;
    logic        resend;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
`ifdef LEAF_IF_STATS_EN
    logic [15:0] rx_cnt;
    logic [15:0] bounce_cnt;
`endif

    int errors = 0;
    int checks = 0;

    leaf_rx_tx_interface #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .m_data                  (m_data),
        .m_valid                 (m_valid),
        .m_ready                 (m_ready),
        .s_data                  (s_data),
        .s_valid                 (s_valid),
        .s_ready                 (s_ready)
`ifdef LEAF_IF_STATS_EN
        ,
        .rx_cnt                  (rx_cnt),
        .bounce_cnt              (bounce_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] pkt(input logic [4:0] leaf, input logic [3:0] port,
                                        input logic [31:0] payload);
        return {1'b1, leaf, port, 1'b0, 6'b0, payload};
    endfunction

    // Reference model: state as seen after the most recent posedge.
    logic [31:0] q[$];
    bit          mdl_cfg;
    logic [4:0]  mdl_leaf;
    logic [3:0]  mdl_port;
    logic [48:0] exp_dout;
    bit          exp_resend;
    int          mdl_rx_cnt;
    int          mdl_bounce_cnt;

    always @(negedge clk) begin
        bit is_data;
        bit bounce;
        bit sready_exp;
        if (!reset_n) begin
            chk("reset_dout", dout, 0);
            chk("reset_resend", resend, 0);
            chk("reset_m_valid", m_valid, 0);
            q.delete();
            mdl_cfg = 0; mdl_leaf = 0; mdl_port = 0;
            exp_dout = 0; exp_resend = 0;
            mdl_rx_cnt = 0; mdl_bounce_cnt = 0;
        end else begin
            is_data    = din[48] && (din[42:39] != 0);
            bounce     = is_data && (q.size() == 16);
            sready_exp = mdl_cfg && !bounce;
            chk("m_valid", m_valid, q.size() != 0);
            if (q.size() != 0) chk("m_data", m_data, q[0]);
            chk("s_ready", s_ready, sready_exp);
            chk("dout", dout, exp_dout);
            chk("resend", resend, exp_resend);
`ifdef LEAF_IF_STATS_EN
            chk("rx_cnt", rx_cnt, mdl_rx_cnt);
            chk("bounce_cnt", bounce_cnt, mdl_bounce_cnt);
`endif
            if (bounce) exp_dout = din | (49'h1 << 38);
            else if (s_valid && sready_exp) exp_dout = pkt(mdl_leaf, mdl_port, s_data);
            else exp_dout = 0;
            exp_resend = bounce;
            if (bounce && mdl_bounce_cnt < 16'hFFFF) mdl_bounce_cnt++;
            if (q.size() != 0 && m_ready) void'(q.pop_front());
            if (is_data && !bounce) begin
                q.push_back(din[31:0]);
                if (mdl_rx_cnt < 16'hFFFF) mdl_rx_cnt++;
            end
            if (din[48] && din[42:39] == 0) begin
                mdl_cfg = 1; mdl_leaf = din[8:4]; mdl_port = din[3:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drained;
        din = 0; s_valid = 0; s_data = 0; m_ready = 0; reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        chk("t0_dout", dout, 0);
        chk("t0_m_valid", m_valid, 0);
        chk("t0_s_ready", s_ready, 0);

        // Config: leaf 2, port 5 from payload 0x25
        din = pkt(5'd3, 4'd0, 32'h25);
        tick();
        din = 0;
        chk("t1_dout", dout, 0);
        chk("t1_s_ready", s_ready, 1);

        din = pkt(5'd1, 4'd1, 32'hDEADBEEF);
        tick();
        din = 0;
        chk("t2_m_valid", m_valid, 1);
        chk("t2_m_data", m_data, 32'hDEADBEEF);
        m_ready = 1;
        tick();
        m_ready = 0;
        chk("t2_m_valid_after_pop", m_valid, 0);

        s_valid = 1; s_data = 32'hCAFE0001;
        #1 chk("t4_s_ready", s_ready, 1);
        tick();
        s_valid = 0;
        chk("t4_dout", dout, 49'h1_1280_CAFE_0001);

        for (int i = 0; i < 16; i++) begin
            din = pkt(5'(i), 4'(1 + i % 15), 32'h100 + 32'(i));
            tick();
        end
        din = pkt(5'd7, 4'd3, 32'h11);
        tick();
        din = 0;
        chk("t3_resend", resend, 1);
        chk("t3_dout", dout, pkt(5'd7, 4'd3, 32'h11) | (49'h1 << 38));
        tick();
        chk("t3_resend_pulse", resend, 0);

        din = pkt(5'd4, 4'd2, 32'h22); s_valid = 1; s_data = 32'h12345678;
        #1 chk("t5_s_ready_blocked", s_ready, 0);
        tick();
        din = 0;
        chk("t5_dout_bounce", dout, pkt(5'd4, 4'd2, 32'h22) | (49'h1 << 38));
        #1 chk("t5_s_ready_free", s_ready, 1);
        tick();
        s_valid = 0;
        chk("t5_dout_tx", dout, pkt(5'd2, 4'd5, 32'h12345678));

        din = pkt(5'd1, 4'd1, 32'h33); m_ready = 1;
        tick();
        din = 0;
        chk("t3b_resend", resend, 1);
        drained = 0;
        for (int i = 0; i < 40 && m_valid; i++) begin
            drained++;
            tick();
        end
        m_ready = 0;
        chk("t3b_count", drained, 15);

        for (int i = 0; i < 5; i++) begin
            din = pkt(5'd9, 4'd6, 32'hA0 + 32'(i));
            if (i == 4) begin s_valid = 1; s_data = 32'h5; end
            tick();
        end
        din = 0; s_valid = 0;
        #2 reset_n = 0;
        #1;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_dout", dout, 0);
        chk("t6_resend", resend, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        chk("t6_empty", m_valid, 0);
        chk("t6_cfg_cleared", s_ready, 0);

        din = pkt(5'd0, 4'd0, $urandom);
        tick();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 60) begin
                din = pkt(5'($urandom), ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                          $urandom);
            end else begin
                din = 49'($urandom) & ~(49'h1 << 48);
            end
            m_ready = ($urandom_range(0, 99) < ((i < 1500) ? 25 : 75));
            s_valid = $urandom_range(0, 1);
            s_data  = $urandom;
            tick();
        end
        din = 0; s_valid = 0; m_ready = 0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
